lsu_mem_arbiter: RTL

Arbitrates scalar/vector load-store traffic from `NUM_CONSUMERS` LSUs onto a single data-memory channel. It sits directly downstream of the per-thread LSUs and upstream of data memory. Each LSU request is presented as a held-valid read or write. The arbiter grants one LSU at a time, forwards the access to memory, relays the response, and completes a full release handshake before it serves the next LSU.

---
 rtl/lsu_mem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - grants one LSU at a time onto a single data-memory channel
// Optional LSU_ARB_RR_EN selects round-robin arbitration; the default build uses fixed priority.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic                               busy
);

  localparam int GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ_WAITING,
    S_WRITE_WAITING,
    S_RELAYING
  } state_t;

  state_t                             r_state;
  logic [GW-1:0]                      r_grant_id;
  logic [GW-1:0]                      r_rr_ptr;
  logic [NUM_CONSUMERS-1:0]           r_consumer_read_ready;
  logic [NUM_CONSUMERS-1:0]           r_consumer_write_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_consumer_read_data;
  logic                               r_mem_read_valid;
  logic [ADDR_BITS-1:0]               r_mem_read_address;
  logic                               r_mem_write_valid;
  logic [ADDR_BITS-1:0]               r_mem_write_address;
  logic [DATA_BITS-1:0]               r_mem_write_data;

  logic [NUM_CONSUMERS-1:0] w_eligible;
  logic                     w_any;
  logic [GW-1:0]            w_win;
  logic                     w_win_read;
  logic                     w_grant_release;
  logic [ADDR_BITS-1:0]     w_win_raddr;
  logic [ADDR_BITS-1:0]     w_win_waddr;
  logic [DATA_BITS-1:0]     w_win_wdata;
  logic [GW-1:0]            w_rr_next;

  assign w_eligible = consumer_read_valid | consumer_write_valid;

`ifdef LSU_ARB_RR_EN
  // Search upward from r_rr_ptr with wrap; first eligible consumer wins.
  always_comb begin
    logic [GW:0]   v_sum;
    logic [GW-1:0] v_idx;
    w_any = 1'b0;
    w_win = '0;
    v_sum = '0;
    v_idx = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (v_sum >= (GW+1)'(NUM_CONSUMERS)) begin
        v_sum = v_sum - (GW+1)'(NUM_CONSUMERS);
      end
      v_idx = v_sum[GW-1:0];
      if (!w_any && w_eligible[v_idx]) begin
        w_any = 1'b1;
        w_win = v_idx;
      end
    end
  end
`else
  // Lowest eligible index wins; r_rr_ptr is tracked but does not steer grants.
  always_comb begin
    logic [GW-1:0] v_idx;
    w_any = 1'b0;
    w_win = '0;
    v_idx = '0;
    for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
      v_idx = GW'(i);
      if (w_eligible[v_idx]) begin
        w_any = 1'b1;
        w_win = v_idx;
      end
    end
  end

  logic w_unused_rr;
  assign w_unused_rr = ^r_rr_ptr;
`endif

  always_comb begin
    w_win_raddr = '0;
    w_win_waddr = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (GW'(i) == w_win) begin
        w_win_raddr = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        w_win_waddr = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        w_win_wdata = consumer_write_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign w_win_read      = consumer_read_valid[w_win];
  assign w_grant_release = !consumer_read_valid[r_grant_id] && !consumer_write_valid[r_grant_id];
  assign w_rr_next       = (r_grant_id == GW'(NUM_CONSUMERS - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state                <= S_IDLE;
      r_grant_id             <= '0;
      r_rr_ptr               <= '0;
      r_consumer_read_ready  <= '0;
      r_consumer_write_ready <= '0;
      r_consumer_read_data   <= '0;
      r_mem_read_valid       <= 1'b0;
      r_mem_read_address     <= '0;
      r_mem_write_valid      <= 1'b0;
      r_mem_write_address    <= '0;
      r_mem_write_data       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_win;
            if (w_win_read) begin
              r_mem_read_valid   <= 1'b1;
              r_mem_read_address <= w_win_raddr;
              r_state            <= S_READ_WAITING;
            end else begin
              r_mem_write_valid   <= 1'b1;
              r_mem_write_address <= w_win_waddr;
              r_mem_write_data    <= w_win_wdata;
              r_state             <= S_WRITE_WAITING;
            end
          end
        end
        S_READ_WAITING: begin
          if (mem_read_ready) begin
            r_mem_read_valid                  <= 1'b0;
            r_consumer_read_ready[r_grant_id] <= 1'b1;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
              if (GW'(i) == r_grant_id) begin
                r_consumer_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
              end
            end
            r_state <= S_RELAYING;
          end
        end
        S_WRITE_WAITING: begin
          if (mem_write_ready) begin
            r_mem_write_valid                  <= 1'b0;
            r_consumer_write_ready[r_grant_id] <= 1'b1;
            r_state                            <= S_RELAYING;
          end
        end
        S_RELAYING: begin
          // Read data slices are deliberately left holding the last response.
          if (w_grant_release) begin
            r_consumer_read_ready  <= '0;
            r_consumer_write_ready <= '0;
            r_rr_ptr               <= w_rr_next;
            r_state                <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign consumer_read_ready  = r_consumer_read_ready;
  assign consumer_write_ready = r_consumer_write_ready;
  assign consumer_read_data   = r_consumer_read_data;
  assign mem_read_valid       = r_mem_read_valid;
  assign mem_read_address     = r_mem_read_address;
  assign mem_write_valid      = r_mem_write_valid;
  assign mem_write_address    = r_mem_write_address;
  assign mem_write_data       = r_mem_write_data;
  assign busy                 = (r_state != S_IDLE);

endmodule
